// File: rtl/jk_register_bank_if.sv
// Signal bundle for jk_register_bank: per-cycle control and data inputs plus
// the registered state, complement, change mask and flip count.
interface jk_register_bank_if #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
);
    logic                 enable;
    logic [1:0]           mode;
    logic [WIDTH-1:0]     j;
    logic [WIDTH-1:0]     k;
    logic [WIDTH-1:0]     load_value;
    logic                 count_clear;
    logic [WIDTH-1:0]     q;
    logic [WIDTH-1:0]     q_not;
    logic [WIDTH-1:0]     changed;
    logic [CNT_WIDTH-1:0] toggle_count;

    modport master (
        output enable, mode, j, k, load_value, count_clear,
        input  q, q_not, changed, toggle_count
    );

    modport slave (
        input  enable, mode, j, k, load_value, count_clear,
        output q, q_not, changed, toggle_count
    );
endinterface

// File: rtl/jk_register_bank.sv
// Bank of WIDTH flip-flops sharing a per-cycle JK/D/T/LOAD mode, with a
// registered complement, a one-cycle change mask and a saturating flip count.
module jk_register_bank #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               CNT_WIDTH   = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    jk_register_bank_if.slave    bus
);

    typedef enum logic [1:0] {
        MODE_JK   = 2'b00,
        MODE_D    = 2'b01,
        MODE_T    = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    localparam int POP_WIDTH = $clog2(WIDTH + 1);
    localparam logic [CNT_WIDTH:0] COUNT_MAX = {1'b0, {CNT_WIDTH{1'b1}}};

    logic [WIDTH-1:0]     q_reg;
    logic [WIDTH-1:0]     q_not_reg;
    logic [WIDTH-1:0]     changed_reg;
    logic [CNT_WIDTH-1:0] count_reg;

    logic [WIDTH-1:0]     q_next;
    logic [WIDTH-1:0]     flips;
    logic [POP_WIDTH-1:0] flip_pop;
    logic [CNT_WIDTH:0]   count_sum;
    logic [CNT_WIDTH-1:0] count_next;

    function automatic logic [POP_WIDTH-1:0] popcount(input logic [WIDTH-1:0] bits);
        logic [POP_WIDTH-1:0] total;
        total = '0;
        for (int i = 0; i < WIDTH; i++) begin
            total = total + POP_WIDTH'(bits[i]);
        end
        return total;
    endfunction

    always_comb begin
        q_next = q_reg;
        if (bus.enable) begin
            case (mode_e'(bus.mode))
                MODE_JK: begin
                    for (int i = 0; i < WIDTH; i++) begin
                        case ({bus.j[i], bus.k[i]})
                            2'b10:   q_next[i] = 1'b1;
                            2'b01:   q_next[i] = 1'b0;
                            2'b11:   q_next[i] = ~q_reg[i];
                            default: q_next[i] = q_reg[i];
                        endcase
                    end
                end
                MODE_D:    q_next = bus.j;
                MODE_T:    q_next = q_reg ^ bus.j;
                MODE_LOAD: q_next = bus.load_value;
                default:   q_next = q_reg;
            endcase
        end
    end

    // The sum is one bit wider than the counter so overflow is seen before the clamp.
    always_comb begin
        flips     = q_next ^ q_reg;
        flip_pop  = popcount(flips);
        count_sum = {1'b0, count_reg} + (CNT_WIDTH + 1)'(flip_pop);
        if (count_sum > COUNT_MAX) begin
            count_next = COUNT_MAX[CNT_WIDTH-1:0];
        end else begin
            count_next = count_sum[CNT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            q_reg       <= RESET_VALUE;
            q_not_reg   <= ~RESET_VALUE;
            changed_reg <= '0;
            count_reg   <= '0;
        end else begin
            q_reg       <= q_next;
            q_not_reg   <= ~q_next;
            changed_reg <= flips;
            if (bus.count_clear) begin
                count_reg <= '0;
            end else if (bus.enable) begin
                count_reg <= count_next;
            end
        end
    end

    assign bus.q            = q_reg;
    assign bus.q_not        = q_not_reg;
    assign bus.changed      = changed_reg;
    assign bus.toggle_count = count_reg;

endmodule

// File: tb/tb_jk_register_bank.sv
// Self-checking bench: three bank configurations driven in lockstep and
// compared every cycle against a word-level model, plus hand-computed values.
module tb_jk_register_bank;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       count_clear = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] j = '0;
    logic [7:0] k = '0;
    logic [7:0] load_value = '0;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    // A: 8 bits, reset A5, 16-bit count. B: 4 bits. C: 8 bits, 4-bit count.
    jk_register_bank_if #(.WIDTH(8), .CNT_WIDTH(16)) bus_a ();
    jk_register_bank_if #(.WIDTH(4), .CNT_WIDTH(16)) bus_b ();
    jk_register_bank_if #(.WIDTH(8), .CNT_WIDTH(4))  bus_c ();

    assign bus_a.enable = enable;       assign bus_b.enable = enable;       assign bus_c.enable = enable;
    assign bus_a.mode = mode;           assign bus_b.mode = mode;           assign bus_c.mode = mode;
    assign bus_a.j = j;                 assign bus_b.j = j[3:0];            assign bus_c.j = j;
    assign bus_a.k = k;                 assign bus_b.k = k[3:0];            assign bus_c.k = k;
    assign bus_a.load_value = load_value;
    assign bus_b.load_value = load_value[3:0];
    assign bus_c.load_value = load_value;
    assign bus_a.count_clear = count_clear;
    assign bus_b.count_clear = count_clear;
    assign bus_c.count_clear = count_clear;

    jk_register_bank #(.WIDTH(8), .RESET_VALUE(8'hA5), .CNT_WIDTH(16)) dut_a (
        .clock(clock), .reset(reset), .bus(bus_a));
    jk_register_bank #(.WIDTH(4), .RESET_VALUE(4'h0), .CNT_WIDTH(16)) dut_b (
        .clock(clock), .reset(reset), .bus(bus_b));
    jk_register_bank #(.WIDTH(8), .RESET_VALUE(8'h00), .CNT_WIDTH(4)) dut_c (
        .clock(clock), .reset(reset), .bus(bus_c));

    logic [7:0] dut_q  [3];
    logic [7:0] dut_qn [3];
    logic [7:0] dut_ch [3];
    int         dut_cnt[3];

    assign dut_q[0]  = bus_a.q;       assign dut_q[1]  = {4'h0, bus_b.q};       assign dut_q[2]  = bus_c.q;
    assign dut_qn[0] = bus_a.q_not;   assign dut_qn[1] = {4'h0, bus_b.q_not};   assign dut_qn[2] = bus_c.q_not;
    assign dut_ch[0] = bus_a.changed; assign dut_ch[1] = {4'h0, bus_b.changed}; assign dut_ch[2] = bus_c.changed;
    assign dut_cnt[0] = int'(bus_a.toggle_count);
    assign dut_cnt[1] = int'(bus_b.toggle_count);
    assign dut_cnt[2] = int'(bus_c.toggle_count);

    logic [7:0] model_mask[3] = '{8'hFF, 8'h0F, 8'hFF};
    logic [7:0] model_rst [3] = '{8'hA5, 8'h00, 8'h00};
    int         model_max [3] = '{65535, 65535, 15};
    logic [7:0] model_q   [3];
    logic [7:0] model_ch  [3];
    int         model_cnt [3];
    logic       model_valid = 1'b0;

    // Word-level model: JK uses the characteristic equation q' = j&~q | ~k&q.
    always @(posedge clock) begin
        logic [7:0] nxt;
        logic [7:0] flips;
        int         sum;
        for (int d = 0; d < 3; d++) begin
            if (reset) begin
                model_q[d]   <= model_rst[d];
                model_ch[d]  <= 8'h00;
                model_cnt[d] <= 0;
            end else begin
                nxt = model_q[d];
                if (enable) begin
                    case (mode)
                        2'b00:   nxt = (j & ~model_q[d]) | (~k & model_q[d]);
                        2'b01:   nxt = j;
                        2'b10:   nxt = model_q[d] ^ j;
                        default: nxt = load_value;
                    endcase
                end
                nxt   = nxt & model_mask[d];
                flips = nxt ^ model_q[d];
                sum   = model_cnt[d] + $countones(flips);
                if (sum > model_max[d]) sum = model_max[d];
                model_q[d]  <= nxt;
                model_ch[d] <= flips;
                if (count_clear) model_cnt[d] <= 0;
                else if (enable) model_cnt[d] <= sum;
            end
        end
        if (reset) model_valid <= 1'b1;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clock) begin
        if (model_valid) begin
            for (int d = 0; d < 3; d++) begin
                checkOutput($sformatf("dut%0d_q", d), int'(dut_q[d]), int'(model_q[d]));
                checkOutput($sformatf("dut%0d_q_not", d), int'(dut_qn[d]), int'(~model_q[d] & model_mask[d]));
                checkOutput($sformatf("dut%0d_changed", d), int'(dut_ch[d]), int'(model_ch[d]));
                checkOutput($sformatf("dut%0d_count", d), dut_cnt[d], model_cnt[d]);
            end
        end
    end

    task automatic applyStimulus(input logic r, input logic en, input logic [1:0] md,
                                 input logic [7:0] jj, input logic [7:0] kk,
                                 input logic [7:0] lv, input logic cc);
        reset       = r;
        enable      = en;
        mode        = md;
        j           = jj;
        k           = kk;
        load_value  = lv;
        count_clear = cc;
        @(posedge clock);
        #1;
    endtask

    initial begin
        applyStimulus(1, 0, 2'b00, 8'h00, 8'h00, 8'h00, 0);
        checkOutput("rst_a_q", int'(bus_a.q), 'hA5);
        checkOutput("rst_a_qn", int'(bus_a.q_not), 'h5A);
        checkOutput("rst_a_changed", int'(bus_a.changed), 0);
        checkOutput("rst_a_count", int'(bus_a.toggle_count), 0);
        checkOutput("rst_b_q", int'(bus_b.q), 0);

        applyStimulus(0, 1, 2'b00, 8'h08, 8'h06, 8'h00, 0);
        checkOutput("jk1_b_q", int'(bus_b.q), 'h8);
        checkOutput("jk1_b_changed", int'(bus_b.changed), 'h8);
        checkOutput("jk1_b_count", int'(bus_b.toggle_count), 1);
        checkOutput("jk1_a_q", int'(bus_a.q), 'hA9);

        applyStimulus(0, 1, 2'b00, 8'hFF, 8'hFF, 8'h00, 0);
        checkOutput("jk2_b_q", int'(bus_b.q), 'h7);
        checkOutput("jk2_b_changed", int'(bus_b.changed), 'hF);
        checkOutput("jk2_b_count", int'(bus_b.toggle_count), 5);
        checkOutput("jk2_a_q", int'(bus_a.q), 'h56);

        applyStimulus(0, 1, 2'b01, 8'h3C, 8'h00, 8'h00, 0);
        checkOutput("d_a_q", int'(bus_a.q), 'h3C);
        checkOutput("d_a_qn", int'(bus_a.q_not), 'hC3);

        applyStimulus(0, 1, 2'b10, 8'hFF, 8'h00, 8'h00, 0);
        checkOutput("t_a_q", int'(bus_a.q), 'hC3);
        checkOutput("t_a_changed", int'(bus_a.changed), 'hFF);
        checkOutput("t_a_count", int'(bus_a.toggle_count), 22);

        applyStimulus(0, 1, 2'b11, 8'h00, 8'h00, 8'hC3, 0);
        checkOutput("load_a_changed", int'(bus_a.changed), 0);
        checkOutput("load_a_count", int'(bus_a.toggle_count), 22);

        for (int n = 0; n < 3; n++) begin
            applyStimulus(0, 0, 2'b10, 8'hFF, 8'h00, 8'h00, 0);
            checkOutput("hold_a_q", int'(bus_a.q), 'hC3);
            checkOutput("hold_a_changed", int'(bus_a.changed), 0);
            checkOutput("hold_a_count", int'(bus_a.toggle_count), 22);
        end

        applyStimulus(0, 0, 2'b10, 8'hFF, 8'h00, 8'h00, 1);
        checkOutput("clr_a_count", int'(bus_a.toggle_count), 0);
        checkOutput("clr_a_q", int'(bus_a.q), 'hC3);

        applyStimulus(0, 1, 2'b10, 8'hFF, 8'h00, 8'h00, 0);
        checkOutput("sat1_c_count", int'(bus_c.toggle_count), 8);
        applyStimulus(0, 1, 2'b10, 8'hFF, 8'h00, 8'h00, 0);
        checkOutput("sat2_c_count", int'(bus_c.toggle_count), 15);
        applyStimulus(0, 1, 2'b10, 8'hFF, 8'h00, 8'h00, 0);
        checkOutput("sat3_c_count", int'(bus_c.toggle_count), 15);
        checkOutput("sat3_c_q", int'(bus_c.q), 'h3C);

        applyStimulus(0, 1, 2'b10, 8'hFF, 8'h00, 8'h00, 1);
        checkOutput("clrt_c_count", int'(bus_c.toggle_count), 0);
        checkOutput("clrt_c_changed", int'(bus_c.changed), 'hFF);
        checkOutput("clrt_c_q", int'(bus_c.q), 'hC3);

        applyStimulus(0, 1, 2'b10, 8'hFF, 8'h00, 8'h00, 0);
        applyStimulus(1, 1, 2'b10, 8'hFF, 8'h00, 8'h00, 1);
        checkOutput("mrst_a_q", int'(bus_a.q), 'hA5);
        checkOutput("mrst_a_qn", int'(bus_a.q_not), 'h5A);
        checkOutput("mrst_a_changed", int'(bus_a.changed), 0);
        checkOutput("mrst_a_count", int'(bus_a.toggle_count), 0);
        checkOutput("mrst_c_q", int'(bus_c.q), 0);

        applyStimulus(0, 1, 2'b10, 8'hFF, 8'h00, 8'h00, 0);
        checkOutput("post_a_q", int'(bus_a.q), 'h5A);
        checkOutput("post_a_count", int'(bus_a.toggle_count), 8);

        applyStimulus(0, 1, 2'b11, 8'h00, 8'h00, 8'h3C, 0);
        checkOutput("load2_a_changed", int'(bus_a.changed), 'h66);
        checkOutput("load2_a_count", int'(bus_a.toggle_count), 12);

        applyStimulus(0, 1, 2'b00, 8'h00, 8'h00, 8'h00, 0);
        checkOutput("jkhold_a_q", int'(bus_a.q), 'h3C);
        checkOutput("jkhold_a_changed", int'(bus_a.changed), 0);

        @(negedge clock);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
